cache_fill_ctrl: RTL

Parametrised, multi-channel cache fill controller. It accepts block-fill requests from NUM_CH caches (channel 0 = I-cache, 1 = D-cache by default) and arbitrates them with fixed priority. It issues one word read per cycle to a fixed-latency pipelined memory and writes the returned words into the owning cache's data array, then writes the tag. It sits between the cache tag/data arrays and the shared main-memory port.

---
 rtl/cache_fill_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cache_fill_ctrl.sv
// Multi-channel cache block fill controller: fixed-priority grant, pipelined word reads, data then tag write.
// Optional macro CACHE_FILL_CRITICAL_WORD_FIRST_EN fetches the missed word first and wraps around the block.
module cache_fill_ctrl #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 16,
    parameter int WORD_BYTES      = 2,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        miss_detected,
    input  logic [NUM_CH*ADDR_W-1:0] miss_address,
    input  logic                     memory_stall,
    output logic [NUM_CH-1:0]        fsm_busy,
    output logic [CH_W-1:0]          fill_channel,
    output logic                     mem_read,
    output logic [ADDR_W-1:0]        memory_address,
    output logic                     write_data_array,
    output logic                     write_tag_array,
    output logic [IDX_W-1:0]         fill_word_offset,
    output logic                     fill_done
);

    localparam int BYTE_BITS = $clog2(WORD_BYTES);
    localparam int OFF_BITS  = $clog2(WORDS_PER_BLOCK * WORD_BYTES);
    localparam int LAST_T    = WORDS_PER_BLOCK + MEM_LATENCY - 1;
    localparam int CNT_W     = $clog2(WORDS_PER_BLOCK + MEM_LATENCY) + 1;
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~((ADDR_W'(1) << OFF_BITS) - ADDR_W'(1));

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    t_q, t_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CH_W-1:0]     owner_q, owner_d;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0]    crit_q, crit_d;
`endif

    logic                grantValid;
    logic [CH_W-1:0]     grantCh;
    logic [ADDR_W-1:0]   grantAddr;
    logic [IDX_W-1:0]    issueIdx;
    logic [IDX_W-1:0]    returnIdx;
    logic                isLast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            base_q  <= '0;
            owner_q <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            crit_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            base_q  <= base_d;
            owner_q <= owner_d;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            crit_q  <= crit_d;
`endif
        end
    end

    // Lowest requesting index wins; scanning downward leaves the smallest set bit.
    always_comb begin
        grantValid = |miss_detected;
        grantCh    = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (miss_detected[c]) grantCh = CH_W'(c);
        end
        grantAddr = miss_address[grantCh*ADDR_W +: ADDR_W];
    end

    // The return index is t-L taken modulo W, which is exact because t-L lies in [0, W).
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign issueIdx  = t_q[IDX_W-1:0] + crit_q;
    assign returnIdx = t_q[IDX_W-1:0] - IDX_W'(MEM_LATENCY) + crit_q;
`else
    assign issueIdx  = t_q[IDX_W-1:0];
    assign returnIdx = t_q[IDX_W-1:0] - IDX_W'(MEM_LATENCY);
`endif

    assign isLast = (t_q == CNT_W'(LAST_T));

    always_comb begin
        state_d          = state_q;
        t_d              = t_q;
        base_d           = base_q;
        owner_d          = owner_q;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        crit_d           = crit_q;
`endif
        fsm_busy         = '0;
        fill_channel     = '0;
        mem_read         = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_word_offset = '0;
        fill_done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    fsm_busy = NUM_CH'(1) << grantCh;
                    owner_d  = grantCh;
                    base_d   = grantAddr & BLOCK_MASK;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                    crit_d   = grantAddr[OFF_BITS-1:BYTE_BITS];
`endif
                    t_d      = '0;
                    state_d  = FILL;
                end
            end
            FILL: begin
                fill_channel = owner_q;
                if (t_q < CNT_W'(WORDS_PER_BLOCK)) begin
                    memory_address = base_q + (ADDR_W'(issueIdx) << BYTE_BITS);
                end
                if (t_q >= CNT_W'(MEM_LATENCY)) begin
                    fill_word_offset = returnIdx;
                end
                // A stall freezes the counter, so the address and offset above stay put by themselves.
                if (!isLast || memory_stall) begin
                    fsm_busy = NUM_CH'(1) << owner_q;
                end
                if (!memory_stall) begin
                    mem_read         = (t_q < CNT_W'(WORDS_PER_BLOCK));
                    write_data_array = (t_q >= CNT_W'(MEM_LATENCY));
                    write_tag_array  = isLast;
                    fill_done        = isLast;
                    if (isLast) begin
                        state_d = IDLE;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            fsm_busy         = '0;
            fill_channel     = '0;
            mem_read         = 1'b0;
            memory_address   = '0;
            write_data_array = 1'b0;
            write_tag_array  = 1'b0;
            fill_word_offset = '0;
            fill_done        = 1'b0;
        end
    end

endmodule
